// File: rtl/regfile_dump.sv
// Register file with NUM_RD registered read ports, one write port and a UART
// dump engine that streams full or dirty-only framed, XOR-checksummed snapshots.
module regfile_dump #(
  parameter int          NUM_REGS = 32,
  parameter int          XLEN     = 32,
  parameter int          NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int          AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk12,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic                     dump_req,
  input  logic                     dump_mode,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     dump_done
);

  localparam int NB = XLEN / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] LAST_REG  = AW'(NUM_REGS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [2:0] {IDLE, SCAN, LOAD, START, WAIT} state_t;
  typedef enum logic [1:0] {K_HDR, K_IDX, K_DATA, K_CSUM} kind_t;
  typedef enum logic [2:0] {LD_NONE, LD_HDR, LD_IDX, LD_DATA, LD_CSUM} ld_t;

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] dirty;
  state_t state, state_next;
  kind_t  kind, kind_next;
  ld_t    ld;
  logic mode, mode_next, pend, pend_next, pend_mode, pend_mode_next;
  logic [AW-1:0] reg_idx, reg_next;
  logic [BW-1:0] byte_idx, byte_next;
  logic [7:0] csum, csum_next, data_next;
  logic clr_en, done_next, wr_ok;

  function automatic logic [7:0] get_byte(input logic [XLEN-1:0] word, input logic [BW-1:0] idx);
    return 8'(word >> (32'd8 * 32'(idx)));
  endfunction

  assign wr_ok = wr_en && (int'(wr_addr) < NUM_REGS) &&
                 !((ZERO_REG == 1'b1) && (wr_addr == {AW{1'b0}}));

  // Register storage and registered read ports (reads see the pre-write value).
  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= {XLEN{1'b0}};
      rd_data <= {(NUM_RD*XLEN){1'b0}};
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      for (int k = 0; k < NUM_RD; k++)
        rd_data[k*XLEN +: XLEN] <= (int'(rd_addr[k*AW +: AW]) < NUM_REGS) ?
                                   regs[rd_addr[k*AW +: AW]] : {XLEN{1'b0}};
    end
  end

  // Dirty tracking: a write in the same cycle as the clear keeps the bit set.
  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      dirty <= {NUM_REGS{1'b0}};
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok && (wr_addr == AW'(r))) dirty[r] <= 1'b1;
        else if (clr_en && (reg_next == AW'(r))) dirty[r] <= 1'b0;
        else dirty[r] <= dirty[r];
      end
    end
  end

  // Next-state logic: first decide what to load next, then perform the load.
  always_comb begin
    state_next = state;    kind_next = kind;     mode_next = mode;
    pend_next  = pend;     pend_mode_next = pend_mode;
    reg_next   = reg_idx;  byte_next = byte_idx;
    csum_next  = csum;     data_next = tx_data;
    ld = LD_NONE; done_next = 1'b0; clr_en = 1'b0;

    if ((state != IDLE) && dump_req && !pend) begin
      pend_next = 1'b1;
      pend_mode_next = dump_mode;
    end else begin
      pend_next = pend;
    end

    case (state)
      IDLE: begin
        if (pend || dump_req) begin
          mode_next = pend ? pend_mode : dump_mode;
          pend_next = 1'b0;
          csum_next = 8'h00;
          reg_next  = {AW{1'b0}};
          byte_next = {BW{1'b0}};
          ld = LD_HDR;
        end else begin
          ld = LD_NONE;
        end
      end
      SCAN: begin
        if (dirty[reg_idx]) ld = LD_IDX;
        else if (reg_idx == LAST_REG) ld = LD_CSUM;
        else reg_next = reg_idx + AW'(1'b1);
      end
      LOAD:  state_next = START;
      START: begin
        if (!tx_ready) state_next = WAIT;
        else state_next = START;
      end
      WAIT: begin
        if (tx_ready) begin
          case (kind)
            K_HDR: begin
              if (mode) state_next = SCAN;
              else ld = LD_DATA;
            end
            K_IDX: ld = LD_DATA;
            K_DATA: begin
              if (byte_idx != LAST_BYTE) begin
                byte_next = byte_idx + BW'(1'b1);
                ld = LD_DATA;
              end else if (reg_idx == LAST_REG) begin
                ld = LD_CSUM;
              end else begin
                reg_next  = reg_idx + AW'(1'b1);
                byte_next = {BW{1'b0}};
                if (mode) state_next = SCAN;
                else ld = LD_DATA;
              end
            end
            K_CSUM: begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
            default: state_next = IDLE;
          endcase
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase

    // Data bytes come from the live register file at load time.
    case (ld)
      LD_HDR:  begin data_next = HEADER; kind_next = K_HDR; state_next = LOAD; end
      LD_IDX:  begin
        data_next = 8'(reg_next); csum_next = csum ^ data_next;
        kind_next = K_IDX; state_next = LOAD;
      end
      LD_DATA: begin
        data_next = get_byte(regs[reg_next], byte_next); csum_next = csum ^ data_next;
        clr_en = (byte_next == {BW{1'b0}}); kind_next = K_DATA; state_next = LOAD;
      end
      LD_CSUM: begin data_next = csum; kind_next = K_CSUM; state_next = LOAD; end
      default: clr_en = 1'b0;
    endcase
  end

  // Engine state and registered outputs.
  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state <= IDLE; kind <= K_HDR; mode <= 1'b0;
      pend <= 1'b0; pend_mode <= 1'b0;
      reg_idx <= {AW{1'b0}}; byte_idx <= {BW{1'b0}}; csum <= 8'h00;
      tx_data <= 8'h00; tx_start <= 1'b0; busy <= 1'b0; dump_done <= 1'b0;
    end else begin
      state <= state_next; kind <= kind_next; mode <= mode_next;
      pend <= pend_next; pend_mode <= pend_mode_next;
      reg_idx <= reg_next; byte_idx <= byte_next; csum <= csum_next;
      tx_data   <= data_next;
      tx_start  <= (state_next == START);
      busy      <= (state_next != IDLE) || pend_next || done_next;
      dump_done <= done_next;
    end
  end

endmodule
